catch_ctrl: RTL and testbench

CATCH_CTRL -- requirements
Module: catch_ctrl

---
 rtl/catch_ctrl.sv | 135 +++++++++++++
 tb/tb_catch_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/catch_ctrl.sv
// rtl/catch_ctrl.sv - throw/catch game controller: frame-paced flight, catch/miss decision, hold timer, score
// Define CATCH_SCORE_EN to build the saturating catch_count register; otherwise catch_count is tied to 8'h00.
module catch_ctrl #(
  parameter logic [7:0] THROW_KEY   = 8'h2C,
  parameter int         HOLD_FRAMES = 30,
  parameter int         SCREEN_W    = 640
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic [7:0]  keycode,
  input  logic [19:0] sprite_xpos,
  input  logic [19:0] sprite_ypos,
  input  logic [9:0]  sprite_W,
  input  logic [9:0]  sprite_H,
  input  logic [9:0]  target_xpos,
  input  logic [9:0]  target_ypos,
  input  logic [9:0]  target_W,
  input  logic [9:0]  target_H,
  output logic        spr_on,
  output logic        inc,
  output logic        hit,
  output logic [7:0]  catch_count,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLIGHT = 2'd1,
    CAUGHT = 2'd2,
    MISS   = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_FRAMES - 1);
  localparam logic [19:0] EDGE_X    = 20'(SCREEN_W);

  state_t      st;
  logic        frame_clk_d;
  logic        fe_q;
  logic        armed;
  logic [15:0] hold_cnt;

  logic [19:0] bx, by, bw, bh, tx, ty, tw, th;
  logic        ov;
  logic        at_edge;

  // All box arithmetic is done at 20 bits with zero-extended 10-bit operands.
  assign bx = sprite_xpos;
  assign by = sprite_ypos;
  assign bw = {10'b0, sprite_W};
  assign bh = {10'b0, sprite_H};
  assign tx = {10'b0, target_xpos};
  assign ty = {10'b0, target_ypos};
  assign tw = {10'b0, target_W};
  assign th = {10'b0, target_H};

  assign ov      = (bx <= tx + tw) & (tx <= bx + bw) & (by <= ty + th) & (ty <= by + bh);
  assign at_edge = (bx + bw) >= EDGE_X;

  assign state = st;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      st          <= IDLE;
      frame_clk_d <= 1'b0;
      fe_q        <= 1'b0;
      armed       <= 1'b0;
      hold_cnt    <= 16'd0;
      spr_on      <= 1'b0;
      inc         <= 1'b0;
      hit         <= 1'b0;
    end else begin
      frame_clk_d <= frame_clk;
      fe_q        <= frame_clk & ~frame_clk_d;
      inc         <= 1'b0;
      hit         <= 1'b0;
      case (st)
        IDLE: begin
          // A held throw key launches once; it must be seen released before the next launch.
          if (fe_q && armed && keycode == THROW_KEY) begin
            st     <= FLIGHT;
            spr_on <= 1'b1;
            inc    <= 1'b1;
            armed  <= 1'b0;
          end else if (keycode != THROW_KEY) begin
            armed <= 1'b1;
          end
        end
        FLIGHT: begin
          if (fe_q) begin
            if (ov) begin
              st       <= CAUGHT;
              spr_on   <= 1'b0;
              hit      <= 1'b1;
              inc      <= 1'b1;
              hold_cnt <= 16'd0;
            end else if (at_edge) begin
              st       <= MISS;
              spr_on   <= 1'b0;
              inc      <= 1'b1;
              hold_cnt <= 16'd0;
            end
          end
        end
        CAUGHT, MISS: begin
          if (fe_q) begin
            if (hold_cnt == HOLD_LAST) begin
              st <= IDLE;
            end else begin
              hold_cnt <= hold_cnt + 16'd1;
            end
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef CATCH_SCORE_EN
  logic [7:0] count_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_q <= 8'h00;
    end else if (hit && count_q != 8'hFF) begin
      count_q <= count_q + 8'h01;
    end
  end

  assign catch_count = count_q;
`else
  assign catch_count = 8'h00;
`endif

endmodule

// File: tb/tb_catch_ctrl.sv
// tb/tb_catch_ctrl.sv - directed self-checking bench for catch_ctrl
module tb_catch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_clk;
  logic [7:0]  keycode;
  logic [19:0] sprite_xpos, sprite_ypos;
  logic [9:0]  sprite_W, sprite_H;
  logic [9:0]  target_xpos, target_ypos, target_W, target_H;
  logic        spr_on, inc, hit;
  logic [7:0]  catch_count;
  logic [1:0]  state;

  int checks   = 0;
  int failures = 0;
  int inc_cnt  = 0;
  int hit_cnt  = 0;

`ifdef CATCH_SCORE_EN
  localparam bit SCORE = 1'b1;
`else
  localparam bit SCORE = 1'b0;
`endif

  catch_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
    .sprite_xpos(sprite_xpos), .sprite_ypos(sprite_ypos),
    .sprite_W(sprite_W), .sprite_H(sprite_H),
    .target_xpos(target_xpos), .target_ypos(target_ypos),
    .target_W(target_W), .target_H(target_H),
    .spr_on(spr_on), .inc(inc), .hit(hit),
    .catch_count(catch_count), .state(state)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (inc === 1'b1) inc_cnt++;
    if (hit === 1'b1) hit_cnt++;
  end

  function automatic logic [31:0] exp_count(input int n);
    return SCORE ? 32'(n) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // One frame tick; returns after the frame's decision has reached the outputs.
  task automatic frame();
    @(negedge Clk);
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic arm_and_throw();
    keycode = 8'h00;
    clocks(1);
    keycode = 8'h2C;
    frame();
  endtask

  task automatic do_catch();
    arm_and_throw();
    frame();
    frames(30);
  endtask

  initial begin
    Reset       = 1'b1;
    frame_clk   = 1'b0;
    keycode     = 8'h2C;
    sprite_xpos = 20'd10;
    sprite_ypos = 20'd192;
    sprite_W    = 10'd20;
    sprite_H    = 10'd20;
    target_xpos = 10'd100;
    target_ypos = 10'd192;
    target_W    = 10'd20;
    target_H    = 10'd20;
    clocks(2);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_spr_on", 32'(spr_on), 32'd0);
    chk("reset_inc", 32'(inc), 32'd0);
    chk("reset_hit", 32'(hit), 32'd0);
    chk("reset_count", 32'(catch_count), 32'd0);
    Reset = 1'b0;
    clocks(2);

    // Key held through reset release must not launch.
    frame();
    chk("no_launch_unarmed", 32'(state), 32'd0);
    chk("no_launch_unarmed_inc", 32'(inc_cnt), 32'd0);

    arm_and_throw();
    chk("throw_state", 32'(state), 32'd1);
    chk("throw_spr_on", 32'(spr_on), 32'd1);
    chk("throw_inc", 32'(inc_cnt), 32'd1);

    for (int x = 12; x <= 78; x += 2) begin
      sprite_xpos = 20'(x);
      frame();
    end
    chk("held_key_no_reinc", 32'(inc_cnt), 32'd1);
    chk("flight_before_touch", 32'(state), 32'd1);

    sprite_xpos = 20'd80;
    clocks(5);
    chk("no_decision_between_frames", 32'(state), 32'd1);
    chk("no_hit_between_frames", 32'(hit_cnt), 32'd0);
    frame();
    chk("catch_state", 32'(state), 32'd2);
    chk("catch_hit", 32'(hit_cnt), 32'd1);
    chk("catch_inc", 32'(inc_cnt), 32'd2);
    chk("catch_spr_off", 32'(spr_on), 32'd0);
    chk("catch_count1", 32'(catch_count), exp_count(1));
    frames(29);
    chk("caught_hold_29", 32'(state), 32'd2);
    frame();
    chk("caught_to_idle_30", 32'(state), 32'd0);

    sprite_xpos = 20'd600;
    sprite_ypos = 20'd0;
    arm_and_throw();
    chk("miss_throw", 32'(state), 32'd1);
    sprite_xpos = 20'd619;
    frame();
    chk("edge_619_stays", 32'(state), 32'd1);
    sprite_xpos = 20'd620;
    frame();
    chk("miss_state", 32'(state), 32'd3);
    chk("miss_no_hit", 32'(hit_cnt), 32'd1);
    chk("miss_inc", 32'(inc_cnt), 32'd4);
    chk("miss_count", 32'(catch_count), exp_count(1));
    frames(29);
    chk("miss_hold_29", 32'(state), 32'd3);
    frame();
    chk("miss_to_idle_30", 32'(state), 32'd0);

    target_xpos = 10'd620;
    target_ypos = 10'd0;
    arm_and_throw();
    frame();
    chk("simul_caught", 32'(state), 32'd2);
    chk("simul_hit", 32'(hit_cnt), 32'd2);
    chk("simul_inc", 32'(inc_cnt), 32'd6);
    chk("simul_count", 32'(catch_count), exp_count(2));
    frames(30);
    chk("simul_idle", 32'(state), 32'd0);

    repeat (254) do_catch();
    chk("sat_hits", 32'(hit_cnt), 32'd256);
    chk("sat_count_ff", 32'(catch_count), exp_count(255));
    do_catch();
    chk("sat_no_wrap", 32'(catch_count), exp_count(255));
    chk("sat_idle", 32'(state), 32'd0);

    arm_and_throw();
    chk("abort_flight", 32'(state), 32'd1);
    @(negedge Clk);
    #1 Reset = 1'b1;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_spr_on", 32'(spr_on), 32'd0);
    chk("async_inc", 32'(inc), 32'd0);
    chk("async_hit", 32'(hit), 32'd0);
    chk("async_count", 32'(catch_count), 32'd0);
    clocks(2);
    Reset = 1'b0;
    clocks(2);
    frame();
    chk("abort_no_hit", 32'(hit_cnt), 32'd257);
    chk("post_reset_unarmed", 32'(state), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
